// File: rtl/exe_iter_divider.sv
// Radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu with tag passthrough and flush.
// Optional DIV_EARLY_OUT_EN: skip iteration when the quotient is trivially zero or divisor is zero.
module exe_iter_divider #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // dq_q starts as |dividend| and fills with quotient bits from the bottom as it shifts.
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] out_quot_q, out_quot_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             sign_a, sign_b, accept, div0_in;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted;
  logic             no_borrow;
  logic [WIDTH-1:0] diff, rem_step, quo_step, quot_fix, rem_fix;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_quot  = out_quot_q;
  assign out_rem   = out_rem_q;
  assign out_tag   = out_tag_q;

  assign sign_a  = in_signed & in_dividend[WIDTH-1];
  assign sign_b  = in_signed & in_divisor[WIDTH-1];
  assign abs_a   = sign_a ? ('0 - in_dividend) : in_dividend;
  assign abs_b   = sign_b ? ('0 - in_divisor) : in_divisor;
  assign div0_in = (in_divisor == '0);
  assign accept  = in_valid & in_ready & ~flush;

  // Compare on the WIDTH+1-bit partial remainder; when it fits, the true difference
  // is below the divisor, so the WIDTH-bit modular subtraction is exact.
  assign shifted   = {rem_q, dq_q[WIDTH-1]};
  assign no_borrow = (shifted >= {1'b0, dsr_q});
  assign diff      = shifted[WIDTH-1:0] - dsr_q;
  assign rem_step  = no_borrow ? diff : shifted[WIDTH-1:0];
  assign quo_step  = {dq_q[WIDTH-2:0], no_borrow};

  assign quot_fix = div0_q ? '1 : (quot_neg_q ? ('0 - quo_step) : quo_step);
  assign rem_fix  = div0_q ? orig_q : (rem_neg_q ? ('0 - rem_step) : rem_step);

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dq_d       = dq_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    orig_d     = orig_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    div0_d     = div0_q;
    out_quot_d = out_quot_q;
    out_rem_d  = out_rem_q;
    out_tag_d  = out_tag_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dq_d       = abs_a;
          dsr_d      = abs_b;
          rem_d      = '0;
          orig_d     = in_dividend;
          quot_neg_d = sign_a ^ sign_b;
          rem_neg_d  = sign_a;
          div0_d     = div0_in;
          out_tag_d  = in_tag;
          cnt_d      = CNT_W'(WIDTH);
          state_d    = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          if (div0_in || (abs_a < abs_b)) begin
            out_quot_d = div0_in ? '1 : '0;
            out_rem_d  = in_dividend;
            state_d    = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        dq_d  = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_quot_d = quot_fix;
          out_rem_d  = rem_fix;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dq_q       <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      orig_q     <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      div0_q     <= 1'b0;
      out_quot_q <= '0;
      out_rem_q  <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dq_q       <= dq_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      orig_q     <= orig_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      div0_q     <= div0_d;
      out_quot_q <= out_quot_d;
      out_rem_q  <= out_rem_d;
      out_tag_q  <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_exe_iter_divider.sv
// Self-checking bench for exe_iter_divider: directed vectors, randomized ops against an
// arithmetic reference model, backpressure, back-to-back handoff, flush and reset cancellation.
module tb_exe_iter_divider;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_signed;
  logic [31:0] in_dividend, in_divisor;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready, busy;
  logic [31:0] out_quot, out_rem;
  logic [4:0]  out_tag;

  int errors = 0;
  int checks = 0;

  exe_iter_divider #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero, remainder follows dividend.
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Cycle (accept = cycle 0) in which out_valid is expected to rise.
  function automatic int exp_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = sgn ? longint'($signed(a)) : longint'({1'b0, a});
    mb = sgn ? longint'($signed(b)) : longint'({1'b0, b});
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || ma < mb) return 1;
`endif
    return 33;
  endfunction

  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    @(negedge clk);
    in_valid = 1'b1; in_signed = sgn; in_dividend = a; in_divisor = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_signed   = 1'($urandom_range(0, 1));
    in_dividend = $urandom;
    in_divisor  = $urandom;
    in_tag      = 5'($urandom);
  endtask

  task automatic wait_result(output int lat, output bit timed_out);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    timed_out = (out_valid !== 1'b1);
  endtask

  task automatic handoff();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b expected 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (out_quot !== 32'd0 || out_rem !== 32'd0 || out_tag !== 5'd0) begin
      errors++;
      $display("FAIL reset_data: got q=%h r=%h t=%h expected zeros", out_quot, out_rem, out_tag);
    end
  endtask

  task automatic test_directed();
    bit          sg [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] va [6] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd3};
    logic [31:0] vb [6] = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd9};
    logic [31:0] eq [6] = '{32'd14, 32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] er [6] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd5, 32'd3};
    logic [4:0]  tg [6] = '{5'h0a, 5'h01, 5'h02, 5'h1f, 5'h10, 5'h04};
    int lat; bit to;
    for (int i = 0; i < 6; i++) begin
      issue(sg[i], va[i], vb[i], tg[i]);
      wait_result(lat, to);
      checks++;
      if (to || lat != exp_lat(sg[i], va[i], vb[i])) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d (timeout=%b) expected %0d", i, lat, to, exp_lat(sg[i], va[i], vb[i]));
      end
      checks++;
      if (out_quot !== eq[i] || out_rem !== er[i] || out_tag !== tg[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got q=%h r=%h t=%h expected q=%h r=%h t=%h",
                 i, out_quot, out_rem, out_tag, eq[i], er[i], tg[i]);
      end
      handoff();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_handoff: got ready=%b valid=%b expected 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r;
    logic [4:0]  tag;
    bit sgn, to;
    int lat;
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      tag = 5'($urandom);
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = $urandom_range(1, 15); end
        2: begin a = $urandom; b = 32'd0; end
        3: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom_range(1, 5); end
        default: begin
          a = $urandom_range(0, 100);
          b = $urandom_range(101, 1000);
          if ($urandom_range(0, 1) == 1) a = 32'd0 - a;
        end
      endcase
      ref_div(sgn, a, b, q, r);
      issue(sgn, a, b, tag);
      wait_result(lat, to);
      checks++;
      if (to || lat != exp_lat(sgn, a, b)) begin
        errors++;
        $display("FAIL rnd%0d_latency: got %0d (timeout=%b) expected %0d", i, lat, to, exp_lat(sgn, a, b));
      end
      checks++;
      if (out_quot !== q || out_rem !== r || out_tag !== tag) begin
        errors++;
        $display("FAIL rnd%0d_result s=%b a=%h b=%h: got q=%h r=%h t=%h expected q=%h r=%h t=%h",
                 i, sgn, a, b, out_quot, out_rem, out_tag, q, r, tag);
      end
      handoff();
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit to;
    issue(1'b1, 32'd100, 32'd7, 5'h0a);
    wait_result(lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL b2b_first: got timeout expected out_valid"); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quot !== 32'd14 || out_rem !== 32'd2 || out_tag !== 5'h0a) begin
        errors++;
        $display("FAIL hold%0d: got v=%b rdy=%b q=%h r=%h t=%h expected 1 0 e 2 0a",
                 i, out_valid, in_ready, out_quot, out_rem, out_tag);
      end
    end
    // Release with the next op already waiting: handoff first, accept one cycle later.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_signed = 1'b0;
    in_dividend = 32'hFFFF_FFF9; in_divisor = 32'd2; in_tag = 5'h03;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_handoff: got v=%b rdy=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b rdy=%b expected 1 0", busy, in_ready);
    end
    wait_result(lat, to);
    checks++;
    if (to || lat != 33 || out_quot !== 32'h7FFF_FFFC || out_rem !== 32'd1 || out_tag !== 5'h03) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d q=%h r=%h t=%h expected 33 7ffffffc 1 03", lat, out_quot, out_rem, out_tag);
    end
    handoff();
  endtask

  task automatic test_cancel(input bit use_reset);
    int lat; bit to;
    issue(1'b0, 32'd1000, 32'd3, 5'h01);
    repeat (9) @(posedge clk);
    @(negedge clk);
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    in_valid = 1'b1; in_signed = 1'b1; in_dividend = 32'hFFFF_FFF9; in_divisor = 32'd2; in_tag = 5'h07;
    @(posedge clk); #1;
    reset = 1'b0; flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cancel%0d_idle: got v=%b busy=%b rdy=%b expected 0 0 1", use_reset, out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL cancel%0d_accept: got busy=%b expected 1", use_reset, busy);
    end
    wait_result(lat, to);
    checks++;
    if (to || lat != 33 || out_quot !== 32'hFFFF_FFFD || out_rem !== 32'hFFFF_FFFF || out_tag !== 5'h07) begin
      errors++;
      $display("FAIL cancel%0d_result: got lat=%0d q=%h r=%h t=%h expected 33 fffffffd ffffffff 07",
               use_reset, lat, out_quot, out_rem, out_tag);
    end
    // Flush while the result is offered: it wins over out_ready.
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL cancel%0d_done_flush: got v=%b rdy=%b expected 0 1", use_reset, out_valid, in_ready);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_dividend = '0; in_divisor = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_cancel(1'b0);
    test_cancel(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
